// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x oversampled, LSB-first, DBIT data bits, SB_TICK-tick stop window.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       s_tick,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frame_err,
   output logic       parity_err,
   output logic       rx_busy
);

   // state  | meaning
   // IDLE   | line idle, waiting for a low level on synchronized rx
   // START  | counting to mid start bit, rejects glitches shorter than half a bit
   // DATA   | sampling DBIT data bits at mid-bit, LSB first
   // PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
   // STOP   | waiting for mid stop bit, then publishing the frame
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   localparam logic [2:0] N_LAST = 3'(DBIT - 1);
   localparam logic [3:0] S_LAST = 4'(SB_TICK - 1);

   state_t          state;
   logic            rx_meta;
   logic            rx_sync;
   logic [3:0]      s;
   logic [2:0]      n;
   logic [DBIT-1:0] b;
`ifdef UART_RX_PARITY_EN
   logic            par_bad;
`endif

   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         rx_meta      <= 1'b1;
         rx_sync      <= 1'b1;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad      <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         rx_meta      <= rx;
         rx_sync      <= rx_meta;
         rx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_sync) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s == 4'd7) begin
                     s <= '0;
                     if (!rx_sync) begin
                        state <= DATA;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == 4'd15) begin
                     s <= '0;
                     b <= {rx_sync, b[DBIT-1:1]};
                     if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 3'd1;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s == 4'd15) begin
                     s       <= '0;
                     par_bad <= (^b) ^ rx_sync;
                     state   <= STOP;
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s == S_LAST) begin
                     s            <= '0;
                     state        <= IDLE;
                     dout         <= 8'(b);
                     frame_err    <= ~rx_sync;
                     rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err   <= par_bad;
`endif
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven on rx, expected results queued and
// checked when rx_done_tick fires.
module tb_uart_rx_frame;

   localparam int DIV    = 4;
   localparam int TCLK   = 16 * DIV;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       s_tick;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
   logic       parity_err;
   logic       rx_busy;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   done_cnt = 0;
   int   tcnt     = 0;
   logic prev_done = 1'b0;

   uart_rx_frame #(.DBIT(8), .SB_TICK(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .s_tick       (s_tick),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .parity_err   (parity_err),
      .rx_busy      (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      s_tick = 1'b0;
      forever begin
         @(negedge clk);
         s_tick = (tcnt == DIV - 1);
         tcnt   = (tcnt == DIV - 1) ? 0 : tcnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_done_tick) begin
         exp_t e;
         done_cnt++;
         check("done_single_cycle", {31'd0, prev_done}, 32'd0);
         check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dout", {24'd0, dout}, {24'd0, e.d});
            check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
            check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
         end
      end
      prev_done = rx_done_tick;
   end

   task automatic drive_bit(input logic v, input int ticks);
      rx = v;
      repeat (ticks * DIV) @(negedge clk);
   endtask

   function automatic logic exp_pe(input logic [7:0] d, input logic par);
`ifdef UART_RX_PARITY_EN
      return (^d) ^ par;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(input logic [7:0] d, input logic fe, input logic par);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      e.pe = exp_pe(d, par);
      exp_q.push_back(e);
   endtask

   // A low stop bit is held for 12 ticks so its mid-bit sample is low while the
   // line is high again well before the receiver re-checks a spurious start.
   task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
      drive_bit(par, 16);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      if (stop_ok) drive_bit(1'b1, 16);
      else begin
         drive_bit(1'b0, 12);
         drive_bit(1'b1, 4);
      end
      rx = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4 * TCLK; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check(tag, exp_q.size(), 32'd0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_done", {31'd0, rx_done_tick}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("rst_busy", {31'd0, rx_busy}, 32'd0);
      rst_n = 1'b1;
      drive_bit(1'b1, 20);

      // valid 0x55
      base = done_cnt;
      push(8'h55, 1'b0, ^8'h55);
      send_frame(8'h55, 1'b1, ^8'h55);
      drain("drain_55");
      drive_bit(1'b1, 16);
      check("cnt_55", done_cnt, base + 1);
      check("busy_after_55", {31'd0, rx_busy}, 32'd0);

      // start glitch of 4 ticks
      base = done_cnt;
      drive_bit(1'b0, 3);
      check("busy_in_glitch", {31'd0, rx_busy}, 32'd1);
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 32);
      check("cnt_glitch", done_cnt, base);
      check("busy_after_glitch", {31'd0, rx_busy}, 32'd0);

      // bad stop, then good frame
      base = done_cnt;
      push(8'hA3, 1'b1, ^8'hA3);
      send_frame(8'hA3, 1'b0, ^8'hA3);
      drain("drain_a3");
      drive_bit(1'b1, 32);
      check("busy_after_a3", {31'd0, rx_busy}, 32'd0);
      push(8'h10, 1'b0, ^8'h10);
      send_frame(8'h10, 1'b1, ^8'h10);
      drain("drain_10");
      drive_bit(1'b1, 16);
      check("cnt_a3_10", done_cnt, base + 2);

      // reset mid-DATA on 0x7E
      base = done_cnt;
      drive_bit(1'b0, 16);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b1, 8);
      check("busy_mid_7e", {31'd0, rx_busy}, 32'd1);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid_dout", {24'd0, dout}, 32'd0);
      check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
      drive_bit(1'b1, 96);
      check("cnt_7e", done_cnt, base);
      push(8'h3C, 1'b0, ^8'h3C);
      send_frame(8'h3C, 1'b1, ^8'h3C);
      drain("drain_3c");
      drive_bit(1'b1, 16);

      // back-to-back
      base = done_cnt;
      push(8'h01, 1'b0, ^8'h01);
      push(8'hFF, 1'b0, ^8'hFF);
      send_frame(8'h01, 1'b1, ^8'h01);
      send_frame(8'hFF, 1'b1, ^8'hFF);
      drain("drain_b2b");
      drive_bit(1'b1, 16);
      check("cnt_b2b", done_cnt, base + 2);

`ifdef UART_RX_PARITY_EN
      base = done_cnt;
      push(8'h07, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      drain("drain_par0");
      drive_bit(1'b1, 16);
      push(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      drain("drain_par1");
      drive_bit(1'b1, 16);
      check("cnt_par", done_cnt, base + 2);
`endif

      check("busy_end", {31'd0, rx_busy}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
